// File: rtl/pwm_timebase.sv
// Shared PWM period timer: prescaled up-counter with double-buffered period/prescale
// and registered period_start / tick / done / update_ack strobes.
module pwm_timebase #(
  parameter int CNT_WIDTH   = 8,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   one_shot,
  input  logic [PRESC_WIDTH-1:0] prescale,
  input  logic [CNT_WIDTH-1:0]   period,
  input  logic                   load,
  output logic [CNT_WIDTH-1:0]   counter,
  output logic                   tick,
  output logic                   period_start,
  output logic                   done,
  output logic                   update_ack,
  output logic                   busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0]   CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]   CNT_ONES   = {CNT_WIDTH{1'b1}};
  localparam logic [PRESC_WIDTH-1:0] PRESC_ZERO = {PRESC_WIDTH{1'b0}};
  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE  = {{(PRESC_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_r, state_s;
  logic [PRESC_WIDTH-1:0] presc_cnt_r, presc_cnt_s;
  logic [PRESC_WIDTH-1:0] presc_act_r, presc_act_s;
  logic [PRESC_WIDTH-1:0] presc_pend_r, presc_pend_s;
  logic [CNT_WIDTH-1:0]   period_act_r, period_act_s;
  logic [CNT_WIDTH-1:0]   period_pend_r, period_pend_s;
  logic                   pend_valid_r, pend_valid_s;
  logic [CNT_WIDTH-1:0]   counter_r, counter_s;
  logic                   tick_r, tick_s;
  logic                   period_start_r, period_start_s;
  logic                   done_r, done_s;
  logic                   update_ack_r, update_ack_s;
  logic                   busy_r, busy_s;
  logic                   term_presc_s;

  // Next-state, buffer management and strobe generation.
  always_comb begin
    state_s        = state_r;
    presc_cnt_s    = presc_cnt_r;
    presc_act_s    = presc_act_r;
    period_act_s   = period_act_r;
    counter_s      = counter_r;
    tick_s         = 1'b0;
    period_start_s = 1'b0;
    done_s         = 1'b0;
    update_ack_s   = 1'b0;
    term_presc_s   = (presc_cnt_r == presc_act_r);

    // A load always lands in the pending buffer; paths below may consume it directly.
    if (load) begin
      presc_pend_s  = prescale;
      period_pend_s = period;
      pend_valid_s  = 1'b1;
    end else begin
      presc_pend_s  = presc_pend_r;
      period_pend_s = period_pend_r;
      pend_valid_s  = pend_valid_r;
    end

    case (state_r)
      ST_IDLE, ST_DONE: begin
        counter_s   = CNT_ZERO;
        presc_cnt_s = PRESC_ZERO;
        // Not counting, so no period can be truncated: apply any update at once.
        if (load) begin
          presc_act_s  = prescale;
          period_act_s = period;
          pend_valid_s = 1'b0;
          update_ack_s = 1'b1;
        end else if (pend_valid_r) begin
          presc_act_s  = presc_pend_r;
          period_act_s = period_pend_r;
          pend_valid_s = 1'b0;
          update_ack_s = 1'b1;
        end else begin
          update_ack_s = 1'b0;
        end
        if (!enable) begin
          state_s = ST_IDLE;
        end else if (state_r == ST_IDLE) begin
          state_s        = ST_RUN;
          period_start_s = 1'b1;
        end else begin
          state_s = ST_DONE;
        end
      end

      ST_RUN: begin
        if (!enable) begin
          state_s     = ST_IDLE;
          counter_s   = CNT_ZERO;
          presc_cnt_s = PRESC_ZERO;
        end else if (!term_presc_s) begin
          presc_cnt_s = presc_cnt_r + PRESC_ONE;
        end else if (counter_r != period_act_r) begin
          presc_cnt_s = PRESC_ZERO;
          counter_s   = counter_r + CNT_ONE;
          tick_s      = 1'b1;
        end else begin
          presc_cnt_s = PRESC_ZERO;
          counter_s   = CNT_ZERO;
          // Boundary: a same-cycle load bypasses the pending buffer.
          if (load) begin
            presc_act_s  = prescale;
            period_act_s = period;
            pend_valid_s = 1'b0;
            update_ack_s = 1'b1;
          end else if (pend_valid_r) begin
            presc_act_s  = presc_pend_r;
            period_act_s = period_pend_r;
            pend_valid_s = 1'b0;
            update_ack_s = 1'b1;
          end else begin
            update_ack_s = 1'b0;
          end
          if (one_shot) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            state_s        = ST_RUN;
            tick_s         = 1'b1;
            period_start_s = 1'b1;
          end
        end
      end

      default: begin
        state_s     = ST_IDLE;
        counter_s   = CNT_ZERO;
        presc_cnt_s = PRESC_ZERO;
      end
    endcase

    busy_s = (state_s == ST_RUN);
  end

  // State, buffer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      presc_cnt_r    <= PRESC_ZERO;
      presc_act_r    <= PRESC_ZERO;
      presc_pend_r   <= PRESC_ZERO;
      period_act_r   <= CNT_ONES;
      period_pend_r  <= CNT_ZERO;
      pend_valid_r   <= 1'b0;
      counter_r      <= CNT_ZERO;
      tick_r         <= 1'b0;
      period_start_r <= 1'b0;
      done_r         <= 1'b0;
      update_ack_r   <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      presc_cnt_r    <= presc_cnt_s;
      presc_act_r    <= presc_act_s;
      presc_pend_r   <= presc_pend_s;
      period_act_r   <= period_act_s;
      period_pend_r  <= period_pend_s;
      pend_valid_r   <= pend_valid_s;
      counter_r      <= counter_s;
      tick_r         <= tick_s;
      period_start_r <= period_start_s;
      done_r         <= done_s;
      update_ack_r   <= update_ack_s;
      busy_r         <= busy_s;
    end
  end

  assign counter      = counter_r;
  assign tick         = tick_r;
  assign period_start = period_start_r;
  assign done         = done_r;
  assign update_ack   = update_ack_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_pwm_timebase.sv
// Scoreboard bench for pwm_timebase: directed per-cycle vectors push expected outputs,
// an independent monitor pops and compares one entry after every rising edge.
module tb_pwm_timebase;

  logic       clk = 1'b0;
  logic       reset, enable, one_shot, load;
  logic [7:0] prescale, period;
  logic [7:0] counter;
  logic       tick, period_start, done, update_ack, busy;

  typedef struct {
    logic [7:0] cnt;
    logic [4:0] fl;   // {tick, period_start, done, update_ack, busy}
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pwm_timebase #(.CNT_WIDTH(8), .PRESC_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .one_shot(one_shot),
    .prescale(prescale), .period(period), .load(load),
    .counter(counter), .tick(tick), .period_start(period_start),
    .done(done), .update_ack(update_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // Push the expected outputs for the coming edge, then wait for the next drive slot.
  task automatic c(input logic [7:0] cnt, input logic [4:0] fl, input string nm);
    exp_t e;
    e.cnt = cnt;
    e.fl  = fl;
    e.nm  = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare DUT outputs against the scoreboard just after each rising edge.
  initial begin
    exp_t       e;
    logic [4:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {tick, period_start, done, update_ack, busy};
        n_tests++;
        if (counter !== e.cnt || got !== e.fl) begin
          n_fail++;
          $display("FAIL %s: got counter=%0d flags(tick,ps,done,ack,busy)=%b, expected counter=%0d flags=%b",
                   e.nm, counter, got, e.cnt, e.fl);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; one_shot = 1'b0; load = 1'b0;
    prescale = 8'd0; period = 8'd3;
    @(negedge clk);

    // Reset values
    c(8'd0, 5'b00000, "reset0");
    c(8'd0, 5'b00000, "reset1");
    reset = 1'b0;

    // Continuous count, prescale 0, period 3
    load = 1'b1; c(8'd0, 5'b00010, "idle_load_ack"); load = 1'b0;
    enable = 1'b1;
    c(8'd0, 5'b01001, "cont_start");
    c(8'd1, 5'b10001, "cont_1");
    c(8'd2, 5'b10001, "cont_2");
    c(8'd3, 5'b10001, "cont_3");
    c(8'd0, 5'b11001, "cont_wrap");
    c(8'd1, 5'b10001, "cont_1b");
    c(8'd2, 5'b10001, "cont_2b");
    c(8'd3, 5'b10001, "cont_3b");
    c(8'd0, 5'b11001, "cont_wrap_b");
    enable = 1'b0;
    c(8'd0, 5'b00000, "cont_stop");

    // Prescaled count, prescale 2, period 1
    prescale = 8'd2; period = 8'd1;
    load = 1'b1; c(8'd0, 5'b00010, "presc_load_ack"); load = 1'b0;
    enable = 1'b1;
    c(8'd0, 5'b01001, "presc_start");
    c(8'd0, 5'b00001, "presc_hold0a");
    c(8'd0, 5'b00001, "presc_hold0b");
    c(8'd1, 5'b10001, "presc_adv1");
    c(8'd1, 5'b00001, "presc_hold1a");
    c(8'd1, 5'b00001, "presc_hold1b");
    c(8'd0, 5'b11001, "presc_wrap");
    c(8'd0, 5'b00001, "presc_hold0c");
    c(8'd0, 5'b00001, "presc_hold0d");
    c(8'd1, 5'b10001, "presc_adv1b");
    enable = 1'b0;
    c(8'd0, 5'b00000, "presc_stop");

    // Mid-period update: period 9, then load 4 while counter shows 5
    prescale = 8'd0; period = 8'd9;
    load = 1'b1; c(8'd0, 5'b00010, "mid_load9_ack"); load = 1'b0;
    enable = 1'b1;
    c(8'd0, 5'b01001, "mid_start");
    for (int i = 1; i <= 5; i++) c(i[7:0], 5'b10001, "mid_run");
    period = 8'd4;
    load = 1'b1; c(8'd6, 5'b10001, "mid_6"); load = 1'b0;
    c(8'd7, 5'b10001, "mid_7");
    c(8'd8, 5'b10001, "mid_8");
    c(8'd9, 5'b10001, "mid_9");
    c(8'd0, 5'b11011, "mid_wrap_ack");
    for (int i = 1; i <= 4; i++) c(i[7:0], 5'b10001, "mid_new_run");

    // Load on the terminal cycle (counter shows 4): new period 2 used immediately
    period = 8'd2;
    load = 1'b1; c(8'd0, 5'b11011, "bnd_wrap_ack"); load = 1'b0;
    c(8'd1, 5'b10001, "bnd_1");
    c(8'd2, 5'b10001, "bnd_2");
    c(8'd0, 5'b11001, "bnd_wrap_no_ack");
    enable = 1'b0;
    c(8'd0, 5'b00000, "bnd_stop");

    // One-shot with period 2
    one_shot = 1'b1; enable = 1'b1;
    c(8'd0, 5'b01001, "os_start");
    c(8'd1, 5'b10001, "os_1");
    c(8'd2, 5'b10001, "os_2");
    c(8'd0, 5'b00100, "os_done");
    c(8'd0, 5'b00000, "os_hold_a");
    c(8'd0, 5'b00000, "os_hold_b");
    enable = 1'b0;
    c(8'd0, 5'b00000, "os_idle");
    enable = 1'b1;
    c(8'd0, 5'b01001, "os_restart");
    c(8'd1, 5'b10001, "os_r1");
    c(8'd2, 5'b10001, "os_r2");
    c(8'd0, 5'b00100, "os_done2");
    enable = 1'b0; one_shot = 1'b0;
    c(8'd0, 5'b00000, "os_idle2");

    // Abort at counter 7
    period = 8'd9;
    load = 1'b1; c(8'd0, 5'b00010, "abort_load_ack"); load = 1'b0;
    enable = 1'b1;
    c(8'd0, 5'b01001, "abort_start");
    for (int i = 1; i <= 7; i++) c(i[7:0], 5'b10001, "abort_run");
    enable = 1'b0;
    c(8'd0, 5'b00000, "abort_zero");
    c(8'd0, 5'b00000, "abort_idle");

    // Reset mid-run with a simultaneous load: update discarded, defaults restored
    enable = 1'b1;
    c(8'd0, 5'b01001, "rst_start");
    c(8'd1, 5'b10001, "rst_1");
    c(8'd2, 5'b10001, "rst_2");
    reset = 1'b1; load = 1'b1; prescale = 8'd1; period = 8'd5;
    c(8'd0, 5'b00000, "rst_apply");
    reset = 1'b0; load = 1'b0;
    c(8'd0, 5'b01001, "rst_restart");
    for (int i = 1; i <= 7; i++) c(i[7:0], 5'b10001, "rst_default_period");
    enable = 1'b0;
    c(8'd0, 5'b00000, "rst_stop");

    // Period 0 with prescale 1: counter stays 0, strobes on every terminal prescaler
    prescale = 8'd1; period = 8'd0;
    load = 1'b1; c(8'd0, 5'b00010, "p0_load_ack"); load = 1'b0;
    enable = 1'b1;
    c(8'd0, 5'b01001, "p0_start");
    c(8'd0, 5'b00001, "p0_wait");
    c(8'd0, 5'b11001, "p0_term");
    c(8'd0, 5'b00001, "p0_wait2");
    c(8'd0, 5'b11001, "p0_term2");
    enable = 1'b0;
    c(8'd0, 5'b00000, "p0_stop");

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
